icescon_master: RTL
===================

Name: icescon_master

Overview:
- ICE-bus initiator: the host-side end of the ICE register bus. Turns single host commands into ICE-bus write and read cycles.
- A write drives ICEIFA/ICEDI and an active-low ICEWR strobe; responders latch on the ICEWR falling edge. A read drives ICEIFA and samples ICEDOP.
- Optional write-verify reads back after a settle delay that covers the responder's two-stage FCLKRT resync. Mismatches retry.
- Typical use: loading the DF-diff unlock key (0xFFAE_6832 at 0x0400_0000) and confirming it took.

Parameters:
- SETUP_CYC, 1: cycles ICEIFA/ICEDI are stable with ICEWR high before the strobe (≥1).
- WR_LOW_CYC, 2: ICEWR low width in cycles (≥1).
- SYNC_CYC, 3: wait between write and verify read (≥2, responder resync depth).
- RD_WAIT_CYC, 1: cycles ICEIFA is driven before ICEDOP is sampled (≥1).
- MAX_RETRY, 2: extra write attempts after a verify mismatch (0..7).

Ports:
- FCLKRT  in  1  clock, all logic on rising edge.
- SYSRSOUTB  in  1  reset, synchronous, active-low.
- CMD_REQ  in  1  command request; sampled only in IDLE.
- CMD_WRITE  in  1  1 = write (+ optional verify), 0 = read only.
- CMD_VERIFY  in  1  1 = read back after write and compare; ignored when CMD_WRITE=0.
- CMD_ADDR  in  32  target address; bits [1:0] are forced to 0 on the bus.
- CMD_WDATA  in  32  write data.
- CMD_ACK  out  1  one-cycle completion pulse.
- CMD_RDATA  out  32  read/verify data; valid with CMD_ACK and held until the next ACK.
- CMD_ERR  out  1  valid with CMD_ACK: verify failed after all retries.
- BUSY  out  1  high from the accept edge through the DONE cycle.
- ICEIFA  out  32  ICE address bus.
- ICEDI  out  32  ICE write-data bus.
- ICEWR  out  1  write strobe, active low, idle high.
- ICEDOP  in  32  responder read data (responders return 0 when not selected).

Behaviour:
- Reset (SYSRSOUTB=0 at a rising edge): state IDLE; ICEWR=1, ICEIFA=0, ICEDI=0, CMD_ACK=0, CMD_ERR=0, CMD_RDATA=0, BUSY=0, retry counter=0.
- Reset applied mid-operation aborts the command. No ACK is issued. ICEWR returns high at that edge, even inside WRLOW.
- All bus outputs are registered. No glitches on ICEWR.
- Idle bus: ICEIFA=0, ICEDI=0, ICEWR=1, so no responder is selected.
- Command capture: in IDLE with CMD_REQ=1, latch CMD_ADDR (with [1:0]=0), CMD_WDATA, CMD_WRITE and CMD_VERIFY, and assert BUSY. Next state is SETUP if CMD_WRITE=1, otherwise RDWAIT. CMD_REQ is ignored in every other state.
- States:
  - SETUP (SETUP_CYC): ICEIFA=addr, ICEDI=wdata, ICEWR=1.
  - WRLOW (WR_LOW_CYC): ICEWR=0, address and data held.
  - HOLD (1 cycle): ICEWR=1, address and data held. Then go to SYNC if verify is set, else DONE.
  - SYNC (SYNC_CYC): bus idle values.
  - RDWAIT (RD_WAIT_CYC): ICEIFA=addr, ICEDI=0, ICEWR=1.
  - SAMPLE (1 cycle): capture ICEDOP into CMD_RDATA.
    - Read-only command: go to DONE.
    - Verify, match: go to DONE with ERR=0.
    - Verify, mismatch and retry count < MAX_RETRY: increment count, go to SETUP.
    - Verify, mismatch and count = MAX_RETRY: go to DONE with ERR=1.
  - DONE (1 cycle): CMD_ACK=1, bus idle. Next state IDLE, BUSY=0, retry counter cleared.
- Write without verify: CMD_RDATA is unchanged and CMD_ERR=0.
- Latency with defaults, counted in cycles after the accept edge:
  - Write+verify, first-pass match: ACK in cycle 10.
  - Write only: ACK in cycle 5.
  - Read only: ACK in cycle 3.
  - Each retry adds 9 cycles.
- A new command can be accepted in the cycle after DONE. Back-to-back commands never merge strobes: there is at least one ICEWR-high cycle (HOLD plus SETUP) between two ICEWR low pulses.
- Phase counters are sized to hold the largest parameter. Each phase lasts exactly its parameter value; there is no off-by-one.

Test Plan:
- Write+verify 0xFFAE_6832 to 0x0400_0000, responder model returning the latched value after 2 FCLKRT → ICEWR low exactly 2 cycles; CMD_ACK in cycle 10; CMD_RDATA=0xFFAE_6832; CMD_ERR=0; one ICEWR pulse total.
- Read-only from 0x0400_0000 with the model holding 0x1234_5678 → ICEWR stays high; ACK in cycle 3; CMD_RDATA=0x1234_5678.
- Write+verify with the model stuck at 0 → 3 ICEWR pulses (1 + MAX_RETRY); ACK in cycle 28; CMD_ERR=1; CMD_RDATA=0.
- Mismatch on the first attempt, match on the second → 2 pulses; ACK in cycle 19; CMD_ERR=0.
- CMD_REQ held high continuously with CMD_ADDR=0x0400_0001 → bus address is 0x0400_0000. The second command is accepted only in the IDLE cycle after DONE, and there is at least one ICEWR-high cycle between the two write pulses.
- SYSRSOUTB low during WRLOW → at the next edge ICEWR=1, ICEIFA=0, BUSY=0, no ACK. After release, a new command completes normally.

Source files
------------

// File: rtl/icescon_master.sv
// ICE-bus initiator: turns single host commands into ICE write/read cycles,
// with optional read-back verify and bounded retry on mismatch.
module icescon_master #(
    parameter int SETUP_CYC   = 1,
    parameter int WR_LOW_CYC  = 2,
    parameter int SYNC_CYC    = 3,
    parameter int RD_WAIT_CYC = 1,
    parameter int MAX_RETRY   = 2
) (
    input  logic        FCLKRT,
    input  logic        SYSRSOUTB,
    input  logic        CMD_REQ,
    input  logic        CMD_WRITE,
    input  logic        CMD_VERIFY,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    output logic        CMD_ACK,
    output logic [31:0] CMD_RDATA,
    output logic        CMD_ERR,
    output logic        BUSY,
    output logic [31:0] ICEIFA,
    output logic [31:0] ICEDI,
    output logic        ICEWR,
    input  logic [31:0] ICEDOP
);

    localparam int MAX_AB = (SETUP_CYC > WR_LOW_CYC) ? SETUP_CYC : WR_LOW_CYC;
    localparam int MAX_CD = (SYNC_CYC > RD_WAIT_CYC) ? SYNC_CYC : RD_WAIT_CYC;
    localparam int MAX_PH = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAX_PH < 2) ? 1 : $clog2(MAX_PH);

    typedef enum logic [2:0] {
        IDLE, SETUP, WRLOW, HOLD, SYNC, RDWAIT, SAMPLE, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    retry, retry_nxt;
    logic          is_wr, is_wr_nxt;
    logic          is_vf, is_vf_nxt;
    logic [31:0]   addr, addr_nxt;
    logic [31:0]   wdata, wdata_nxt;
    logic [31:0]   rdata_nxt;
    logic          err_nxt;
    logic          drive_a, drive_d;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry;
        is_wr_nxt = is_wr;
        is_vf_nxt = is_vf;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        rdata_nxt = CMD_RDATA;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (CMD_REQ) begin
                    addr_nxt  = CMD_ADDR & ~32'h3;
                    wdata_nxt = CMD_WDATA;
                    is_wr_nxt = CMD_WRITE;
                    is_vf_nxt = CMD_VERIFY & CMD_WRITE;
                    if (CMD_WRITE) begin
                        state_nxt = SETUP;
                        cnt_nxt   = CW'(SETUP_CYC - 1);
                    end else begin
                        state_nxt = RDWAIT;
                        cnt_nxt   = CW'(RD_WAIT_CYC - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = WRLOW;
                    cnt_nxt   = CW'(WR_LOW_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WRLOW: begin
                if (cnt == '0) state_nxt = HOLD;
                else           cnt_nxt   = cnt - CW'(1);
            end
            HOLD: begin
                if (is_vf) begin
                    state_nxt = SYNC;
                    cnt_nxt   = CW'(SYNC_CYC - 1);
                end else begin
                    state_nxt = DONE;
                end
            end
            SYNC: begin
                if (cnt == '0) begin
                    state_nxt = RDWAIT;
                    cnt_nxt   = CW'(RD_WAIT_CYC - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RDWAIT: begin
                if (cnt == '0) state_nxt = SAMPLE;
                else           cnt_nxt   = cnt - CW'(1);
            end
            SAMPLE: begin
                rdata_nxt = ICEDOP;
                if (!is_wr || ICEDOP == wdata) begin
                    state_nxt = DONE;
                end else if (retry < 3'(MAX_RETRY)) begin
                    retry_nxt = retry + 3'd1;
                    state_nxt = SETUP;
                    cnt_nxt   = CW'(SETUP_CYC - 1);
                end else begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                retry_nxt = 3'd0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so every pin comes straight off a flop.
    assign drive_a = (state_nxt == SETUP) || (state_nxt == WRLOW) || (state_nxt == HOLD) ||
                     (state_nxt == RDWAIT) || (state_nxt == SAMPLE);
    assign drive_d = (state_nxt == SETUP) || (state_nxt == WRLOW) || (state_nxt == HOLD);

    always_ff @(posedge FCLKRT) begin
        if (!SYSRSOUTB) begin
            state     <= IDLE;
            cnt       <= '0;
            retry     <= 3'd0;
            is_wr     <= 1'b0;
            is_vf     <= 1'b0;
            ICEWR     <= 1'b1;
            ICEIFA    <= '0;
            ICEDI     <= '0;
            CMD_ACK   <= 1'b0;
            CMD_ERR   <= 1'b0;
            CMD_RDATA <= '0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry     <= retry_nxt;
            is_wr     <= is_wr_nxt;
            is_vf     <= is_vf_nxt;
            ICEWR     <= (state_nxt != WRLOW);
            ICEIFA    <= drive_a ? addr_nxt : '0;
            ICEDI     <= drive_d ? wdata_nxt : '0;
            CMD_ACK   <= (state_nxt == DONE);
            CMD_ERR   <= err_nxt;
            CMD_RDATA <= rdata_nxt;
            BUSY      <= (state_nxt != IDLE);
        end
    end

    // Command payload only changes on accept, so it needs no reset.
    always_ff @(posedge FCLKRT) begin
        addr  <= addr_nxt;
        wdata <= wdata_nxt;
    end

endmodule
